// File: rtl/scarv_cpu_cop_if_pkg.sv
// Shared types and constants for the CPU-side COP instruction interface.
package scarv_cpu_cop_if_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned RESULT_W   = 3;

    // COP instruction result codes
    localparam logic [RESULT_W-1:0] SCARV_COP_INSN_SUCCESS = 3'b000;
    localparam logic [RESULT_W-1:0] SCARV_COP_INSN_ABORT   = 3'b001;
    localparam logic [RESULT_W-1:0] SCARV_COP_INSN_BAD_INS = 3'b010;
    localparam logic [RESULT_W-1:0] SCARV_COP_INSN_BAD_LAD = 3'b100;
    localparam logic [RESULT_W-1:0] SCARV_COP_INSN_BAD_SAD = 3'b101;
    localparam logic [RESULT_W-1:0] SCARV_COP_INSN_LD_ERR  = 3'b110;
    localparam logic [RESULT_W-1:0] SCARV_COP_INSN_ST_ERR  = 3'b111;

    // Interface FSM states
    typedef enum logic [2:0] {
        SCARV_CPU_COP_FSM_IDLE  = 3'd0,
        SCARV_CPU_COP_FSM_REQ   = 3'd1,
        SCARV_CPU_COP_FSM_WAIT  = 3'd2,
        SCARV_CPU_COP_FSM_HOLD  = 3'd3,
        SCARV_CPU_COP_FSM_DRAIN = 3'd4
    } cop_fsm_t;

    // Writeback payload held for the pipeline
    typedef struct packed {
        logic                  wen;
        logic [REG_ADDR_W-1:0] waddr;
        logic [XLEN-1:0]       wdata;
        logic [RESULT_W-1:0]   result;
        logic                  timeout;
    } cop_wb_t;

    // A faulting instruction never writes a GPR
    function automatic logic gpr_wen(input logic wen, input logic [RESULT_W-1:0] result);
        return wen && (result == SCARV_COP_INSN_SUCCESS);
    endfunction

endpackage

// File: rtl/scarv_cpu_cop_wdog.sv
// Watchdog for an outstanding COP instruction: counts waiting cycles and
// flags expiry on the last allowed cycle.
module scarv_cpu_cop_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic g_clk,
    input  logic g_reset,
    input  logic clr,
    input  logic run,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Cycle counter: cleared on entry to a waiting state, advances while waiting
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire_c = run && (cnt_q == LIMIT);

endmodule

// File: rtl/scarv_cpu_cop_if.sv
// CPU-side initiator of the CPU/COP instruction interface. Issues one ISE
// instruction to the COP, runs the req/ack and rsp/ack handshakes, handles
// pipeline flushes and returns the writeback to the pipeline.
// Optional feature: define SCARV_CPU_COP_TIMEOUT_EN to add a watchdog that
// abandons an instruction after TIMEOUT_CYCLES cycles without a response.
module scarv_cpu_cop_if
    import scarv_cpu_cop_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  g_clk,
    input  logic                  g_reset,

    input  logic                  pipe_valid,
    output logic                  pipe_ready,
    input  logic [XLEN-1:0]       pipe_insn,
    input  logic [XLEN-1:0]       pipe_rs1,
    input  logic                  pipe_flush,

    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic                  wb_wen,
    output logic [REG_ADDR_W-1:0] wb_waddr,
    output logic [XLEN-1:0]       wb_wdata,
    output logic [RESULT_W-1:0]   wb_result,
    output logic                  wb_timeout,

    output logic                  cpu_insn_req,
    input  logic                  cop_insn_ack,
    output logic                  cpu_abort_req,
    output logic [XLEN-1:0]       cpu_insn_enc,
    output logic [XLEN-1:0]       cpu_rs1,

    input  logic                  cop_wen,
    input  logic [REG_ADDR_W-1:0] cop_waddr,
    input  logic [XLEN-1:0]       cop_wdata,
    input  logic [RESULT_W-1:0]   cop_result,
    input  logic                  cop_insn_rsp,
    output logic                  cpu_insn_ack
);

    cop_fsm_t state_q;
    cop_fsm_t state_d;
    cop_wb_t  wb_q;

    logic accept_c;
    logic capture_c;
    logic timeout_c;
    logic abort_d;
    logic wd_expire_c;

    // A limit below 2 would expire on the first waiting cycle
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("scarv_cpu_cop_if: TIMEOUT_CYCLES must be at least 2");
    end

`ifdef SCARV_CPU_COP_TIMEOUT_EN
    logic wd_clr_c;
    logic wd_run_c;

    assign wd_clr_c = (state_d != state_q) &&
                      ((state_d == SCARV_CPU_COP_FSM_WAIT) || (state_d == SCARV_CPU_COP_FSM_DRAIN));
    assign wd_run_c = ((state_q == SCARV_CPU_COP_FSM_WAIT) || (state_q == SCARV_CPU_COP_FSM_DRAIN)) &&
                      !cop_insn_rsp;

    scarv_cpu_cop_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .g_clk    (g_clk),
        .g_reset  (g_reset),
        .clr      (wd_clr_c),
        .run      (wd_run_c),
        .expire_c (wd_expire_c)
    );
`else
    assign wd_expire_c = 1'b0;
`endif

    // State register
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= SCARV_CPU_COP_FSM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            SCARV_CPU_COP_FSM_IDLE: begin
                if (pipe_valid && !pipe_flush) state_d = SCARV_CPU_COP_FSM_REQ;
            end
            SCARV_CPU_COP_FSM_REQ: begin
                // Once the COP has accepted, it must be drained even if flushed
                if (cop_insn_ack)    state_d = pipe_flush ? SCARV_CPU_COP_FSM_DRAIN : SCARV_CPU_COP_FSM_WAIT;
                else if (pipe_flush) state_d = SCARV_CPU_COP_FSM_IDLE;
            end
            SCARV_CPU_COP_FSM_WAIT: begin
                if (cop_insn_rsp)     state_d = pipe_flush ? SCARV_CPU_COP_FSM_IDLE : SCARV_CPU_COP_FSM_HOLD;
                else if (pipe_flush)  state_d = SCARV_CPU_COP_FSM_DRAIN;
                else if (wd_expire_c) state_d = SCARV_CPU_COP_FSM_HOLD;
            end
            SCARV_CPU_COP_FSM_HOLD: begin
                if (wb_ready || pipe_flush) state_d = SCARV_CPU_COP_FSM_IDLE;
            end
            SCARV_CPU_COP_FSM_DRAIN: begin
                if (cop_insn_rsp || wd_expire_c) state_d = SCARV_CPU_COP_FSM_IDLE;
            end
            default: state_d = SCARV_CPU_COP_FSM_IDLE;
        endcase
    end

    // Output decode and datapath events
    always_comb begin
        pipe_ready   = 1'b0;
        cpu_insn_req = 1'b0;
        cpu_insn_ack = 1'b0;
        wb_valid     = 1'b0;
        accept_c     = 1'b0;
        capture_c    = 1'b0;
        timeout_c    = 1'b0;
        abort_d      = 1'b0;
        case (state_q)
            SCARV_CPU_COP_FSM_IDLE: begin
                pipe_ready = !g_reset;
                accept_c   = pipe_valid && !pipe_flush;
            end
            SCARV_CPU_COP_FSM_REQ: begin
                cpu_insn_req = 1'b1;
                abort_d      = cop_insn_ack && pipe_flush;
            end
            SCARV_CPU_COP_FSM_WAIT: begin
                cpu_insn_ack = cop_insn_rsp;
                capture_c    = cop_insn_rsp && !pipe_flush;
                abort_d      = !cop_insn_rsp && (pipe_flush || wd_expire_c);
                timeout_c    = !cop_insn_rsp && !pipe_flush && wd_expire_c;
            end
            SCARV_CPU_COP_FSM_HOLD: begin
                wb_valid = 1'b1;
            end
            SCARV_CPU_COP_FSM_DRAIN: begin
                cpu_insn_ack = cop_insn_rsp;
                abort_d      = !cop_insn_rsp && wd_expire_c;
            end
            default: begin
            end
        endcase
    end

    // Registered instruction, abort pulse and writeback payload
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            cpu_insn_enc  <= '0;
            cpu_rs1       <= '0;
            cpu_abort_req <= 1'b0;
            wb_q          <= '0;
        end else begin
            cpu_abort_req <= abort_d;
            if (accept_c) begin
                cpu_insn_enc <= pipe_insn;
                cpu_rs1      <= pipe_rs1;
            end
            if (capture_c) begin
                wb_q.wen     <= gpr_wen(cop_wen, cop_result);
                wb_q.waddr   <= cop_waddr;
                wb_q.wdata   <= cop_wdata;
                wb_q.result  <= cop_result;
                wb_q.timeout <= 1'b0;
            end else if (timeout_c) begin
                wb_q.wen     <= 1'b0;
                wb_q.waddr   <= '0;
                wb_q.wdata   <= '0;
                wb_q.result  <= SCARV_COP_INSN_BAD_INS;
                wb_q.timeout <= 1'b1;
            end
        end
    end

    assign wb_wen     = wb_q.wen;
    assign wb_waddr   = wb_q.waddr;
    assign wb_wdata   = wb_q.wdata;
    assign wb_result  = wb_q.result;
    assign wb_timeout = wb_q.timeout;

endmodule

// File: tb/tb_scarv_cpu_cop_if.sv
// Directed bench for scarv_cpu_cop_if: cycle-by-cycle vector table plus
// hand-written sequences for stalls, timeouts and mid-operation reset.
module tb_scarv_cpu_cop_if;
    import scarv_cpu_cop_if_pkg::*;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        pipe_valid, pipe_ready, pipe_flush;
    logic [31:0] pipe_insn, pipe_rs1;
    logic        wb_valid, wb_ready, wb_wen, wb_timeout;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [2:0]  wb_result;
    logic        cpu_insn_req, cop_insn_ack, cpu_abort_req;
    logic [31:0] cpu_insn_enc, cpu_rs1;
    logic        cop_wen;
    logic [4:0]  cop_waddr;
    logic [31:0] cop_wdata;
    logic [2:0]  cop_result;
    logic        cop_insn_rsp, cpu_insn_ack;

    int checks   = 0;
    int failures = 0;

    always #5 g_clk = ~g_clk;

    scarv_cpu_cop_if #(.TIMEOUT_CYCLES(8)) dut (
        .g_clk        (g_clk),
        .g_reset      (g_reset),
        .pipe_valid   (pipe_valid),
        .pipe_ready   (pipe_ready),
        .pipe_insn    (pipe_insn),
        .pipe_rs1     (pipe_rs1),
        .pipe_flush   (pipe_flush),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_wen       (wb_wen),
        .wb_waddr     (wb_waddr),
        .wb_wdata     (wb_wdata),
        .wb_result    (wb_result),
        .wb_timeout   (wb_timeout),
        .cpu_insn_req (cpu_insn_req),
        .cop_insn_ack (cop_insn_ack),
        .cpu_abort_req(cpu_abort_req),
        .cpu_insn_enc (cpu_insn_enc),
        .cpu_rs1      (cpu_rs1),
        .cop_wen      (cop_wen),
        .cop_waddr    (cop_waddr),
        .cop_wdata    (cop_wdata),
        .cop_result   (cop_result),
        .cop_insn_rsp (cop_insn_rsp),
        .cpu_insn_ack (cpu_insn_ack)
    );

    // One row = one clock cycle. in_c = {pv, pf, wr, ack, rsp};
    // e_c = {pipe_ready, cpu_insn_req, cpu_insn_ack, cpu_abort_req, wb_valid}.
    typedef struct {
        logic [4:0]  in_c;
        logic [4:0]  e_c;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  res;
        logic        chk_wb;
        logic [41:0] e_wb;
    } vec_t;

    localparam int NV = 36;
    vec_t vecs[NV];

    function automatic vec_t v(input logic [4:0] in_c, input logic [4:0] e_c,
                               input logic wen, input logic [4:0] waddr,
                               input logic [31:0] wdata, input logic [2:0] res);
        vec_t r;
        r.in_c = in_c; r.e_c = e_c;
        r.wen = wen; r.waddr = waddr; r.wdata = wdata; r.res = res;
        r.chk_wb = 1'b0; r.e_wb = '0;
        return r;
    endfunction

    // HOLD row: COP drives unrelated data, wb_* must stay at the captured values
    function automatic vec_t h(input logic [4:0] in_c, input logic [4:0] e_c,
                               input logic ewen, input logic [4:0] ewaddr,
                               input logic [31:0] ewdata, input logic [2:0] eres);
        vec_t r;
        r.in_c = in_c; r.e_c = e_c;
        r.wen = ~ewen; r.waddr = ~ewaddr; r.wdata = ~ewdata; r.res = ~eres;
        r.chk_wb = 1'b1; r.e_wb = {ewen, ewaddr, ewdata, eres, 1'b0};
        return r;
    endfunction

    function automatic logic [4:0] ctl();
        return {pipe_ready, cpu_insn_req, cpu_insn_ack, cpu_abort_req, wb_valid};
    endfunction

    function automatic logic [41:0] wbo();
        return {wb_wen, wb_waddr, wb_wdata, wb_result, wb_timeout};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] c);
        {pipe_valid, pipe_flush, wb_ready, cop_insn_ack, cop_insn_rsp} = c;
    endtask

    task automatic cop_data(input logic wen, input logic [4:0] a, input logic [31:0] d, input logic [2:0] r);
        cop_wen = wen; cop_waddr = a; cop_wdata = d; cop_result = r;
    endtask

    initial begin
        logic ok;

        vecs[0]  = v(5'b10000, 5'b10000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[1]  = v(5'b00010, 5'b01000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[2]  = v(5'b00000, 5'b00000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[3]  = v(5'b00000, 5'b00000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[4]  = v(5'b00001, 5'b00100, 1'b1, 5'd5, 32'hDEADBEEF, SCARV_COP_INSN_SUCCESS);
        vecs[5]  = h(5'b00100, 5'b00001, 1'b1, 5'd5, 32'hDEADBEEF, 3'd0);
        vecs[6]  = v(5'b00000, 5'b10000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[7]  = v(5'b10000, 5'b10000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[8]  = v(5'b00010, 5'b01000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[9]  = v(5'b00001, 5'b00100, 1'b1, 5'd7, 32'h0BADF00D, SCARV_COP_INSN_LD_ERR);
        vecs[10] = h(5'b00100, 5'b00001, 1'b0, 5'd7, 32'h0BADF00D, 3'b110);
        vecs[11] = v(5'b10000, 5'b10000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[12] = v(5'b01000, 5'b01000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[13] = v(5'b11000, 5'b10000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[14] = v(5'b00000, 5'b10000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[15] = v(5'b10000, 5'b10000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[16] = v(5'b01010, 5'b01000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[17] = v(5'b00000, 5'b00010, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[18] = v(5'b00001, 5'b00100, 1'b1, 5'd3, 32'h1, 3'd0);
        vecs[19] = v(5'b00000, 5'b10000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[20] = v(5'b10000, 5'b10000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[21] = v(5'b00010, 5'b01000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[22] = v(5'b01000, 5'b00000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[23] = v(5'b00000, 5'b00010, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[24] = v(5'b00001, 5'b00100, 1'b1, 5'd4, 32'h2, 3'd0);
        vecs[25] = v(5'b00000, 5'b10000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[26] = v(5'b10000, 5'b10000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[27] = v(5'b00010, 5'b01000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[28] = v(5'b01001, 5'b00100, 1'b1, 5'd6, 32'h3, 3'd0);
        vecs[29] = v(5'b00000, 5'b10000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[30] = v(5'b10000, 5'b10000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[31] = v(5'b00010, 5'b01000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[32] = v(5'b00001, 5'b00100, 1'b1, 5'd9, 32'h11, 3'd0);
        vecs[33] = h(5'b01000, 5'b00001, 1'b1, 5'd9, 32'h11, 3'd0);
        vecs[34] = v(5'b00000, 5'b10000, 1'b0, 5'd0, 32'h0, 3'd0);
        vecs[35] = v(5'b00000, 5'b10000, 1'b0, 5'd0, 32'h0, 3'd0);

        g_reset = 1'b1;
        drive(5'b00000);
        cop_data(1'b0, 5'd0, 32'h0, 3'd0);
        pipe_insn = 32'h0000_200B;
        pipe_rs1  = 32'h1234_5678;

        // Reset state
        step(); step(); #1;
        check("reset_ctl", 64'(ctl()), 64'h0);
        check("reset_insn_rs1", {cpu_insn_enc, cpu_rs1}, 64'h0);
        check("reset_wb", 64'(wbo()), 64'h0);
        step();
        g_reset = 1'b0;

        // Cycle table
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].in_c);
            cop_data(vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].res);
            #1;
            check($sformatf("row%0d_ctl", i), 64'(ctl()), 64'(vecs[i].e_c));
            if (vecs[i].chk_wb) check($sformatf("row%0d_wb", i), 64'(wbo()), 64'(vecs[i].e_wb));
            step();
        end
        drive(5'b00000);

        // Writeback stall in HOLD
        pipe_insn = 32'hABCD_200B; pipe_rs1 = 32'hCAFE_F00D;
        drive(5'b10000); #1; step();
        drive(5'b00010); #1;
        check("stall_insn_rs1", {cpu_insn_enc, cpu_rs1}, 64'hABCD_200B_CAFE_F00D);
        check("stall_req", 64'(cpu_insn_req), 64'h1);
        step();
        drive(5'b00001); cop_data(1'b1, 5'd31, 32'h55AA_55AA, 3'd0); #1;
        check("stall_rsp_ack", 64'(cpu_insn_ack), 64'h1);
        step();
        for (int c = 0; c < 5; c++) begin
            drive(5'b10000); cop_data(1'b0, 5'd1, 32'h0, 3'd7); #1;
            check($sformatf("stall%0d_ctl", c), 64'(ctl()), 64'(5'b00001));
            check($sformatf("stall%0d_wb", c), 64'(wbo()), 64'({1'b1, 5'd31, 32'h55AA_55AA, 3'd0, 1'b0}));
            step();
        end
        drive(5'b00100); #1;
        check("stall_release", 64'(wb_valid), 64'h1);
        step();
        drive(5'b00000); #1;
        check("stall_ready_after", 64'(ctl()), 64'(5'b10000));
        step();

`ifdef SCARV_CPU_COP_TIMEOUT_EN
        // Watchdog expiry in WAIT
        drive(5'b10000); #1; step();
        drive(5'b00010); #1; step();
        drive(5'b00000);
        ok = 1'b1;
        for (int s = 0; s < 8; s++) begin
            #1;
            if (wb_valid || cpu_abort_req) ok = 1'b0;
            step();
        end
        check("tmo_wait_quiet", 64'(ok), 64'h1);
        #1;
        check("tmo_wait_expire", 64'({cpu_abort_req, wb_valid, wb_timeout, wb_wen, wb_result}),
              64'({1'b1, 1'b1, 1'b1, 1'b0, SCARV_COP_INSN_BAD_INS}));
        step();
        drive(5'b00100); #1;
        check("tmo_abort_pulse", 64'({cpu_abort_req, wb_valid}), 64'(2'b01));
        step();
        // Watchdog expiry in DRAIN
        drive(5'b10000); #1; step();
        drive(5'b00010); #1; step();
        drive(5'b01000); #1; step();
        drive(5'b00000);
        ok = 1'b1;
        for (int s = 0; s < 8; s++) begin
            #1;
            if (pipe_ready || wb_valid) ok = 1'b0;
            step();
        end
        check("tmo_drain_quiet", 64'(ok), 64'h1);
        #1;
        check("tmo_drain_expire", 64'({pipe_ready, cpu_abort_req, wb_valid}), 64'(3'b110));
        step();
`else
        // No watchdog: WAIT persists indefinitely
        drive(5'b10000); #1; step();
        drive(5'b00010); #1; step();
        drive(5'b00000);
        ok = 1'b1;
        for (int s = 0; s < 1000; s++) begin
            #1;
            if (ctl() != 5'b00000) ok = 1'b0;
            step();
        end
        check("notmo_still_wait", 64'(ok), 64'h1);
        drive(5'b00001); cop_data(1'b1, 5'd2, 32'h77, 3'd0); #1;
        check("notmo_late_rsp", 64'(cpu_insn_ack), 64'h1);
        step();
        drive(5'b00100); #1;
        check("notmo_wb", 64'({wb_valid, wbo()}), 64'({1'b1, 1'b1, 5'd2, 32'h77, 3'd0, 1'b0}));
        step();
`endif

        // Reset while waiting for a response
        drive(5'b00000);
        pipe_insn = 32'h0000_300B;
        drive(5'b10000); #1; step();
        drive(5'b00010); #1; step();
        drive(5'b00000);
        g_reset = 1'b1; #1;
        check("rst_mid_ready_low", 64'(pipe_ready), 64'h0);
        step();
        g_reset = 1'b0; #1;
        check("rst_mid_regs", {cpu_insn_enc, cpu_rs1}, 64'h0);
        check("rst_mid_state", 64'({ctl(), wbo()}), 64'({5'b10000, 42'h0}));
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
